// File: rtl/mem_hs.sv
// Data memory with valid/ready request and response channels, configurable latency,
// byte-strobe writes and an out-of-window error flag.
module mem_hs #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 32,
  parameter int                 DEPTH     = 1024,
  parameter int                 LATENCY   = 1,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h8000_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_req_valid,
  output logic                io_req_ready,
  input  logic                io_req_wr,
  input  logic [ADDR_W-1:0]   io_req_addr,
  input  logic [DATA_W-1:0]   io_req_wdata,
  input  logic [DATA_W/8-1:0] io_req_wstrb,
  output logic                io_resp_valid,
  input  logic                io_resp_ready,
  output logic [DATA_W-1:0]   io_resp_rdata,
  output logic                io_resp_err
);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | latency countdown in progress
  // RESP  | response held until consumer accepts
  localparam int STRB_W = DATA_W / 8;
  localparam int SHIFT  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                live_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                enter_resp;
  logic                use_in;
  logic                op_wr;
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   op_wdata;
  logic [STRB_W-1:0]   op_wstrb;
  logic [ADDR_W-1:0]   offset;
  logic [IDX_W-1:0]    idx;
  logic                in_range;
  logic                we;

  // live_q keeps ready low while reset is held, without a path from reset to the port
  assign io_req_ready  = (state_q == IDLE) && live_q;
  assign io_resp_valid = (state_q == RESP);
  assign io_resp_rdata = rdata_q;
  assign io_resp_err   = err_q;
  assign accept        = io_req_valid && io_req_ready;

  // With LATENCY=1 the array is accessed on the accept edge, so take the live inputs
  assign use_in   = (state_q == IDLE);
  assign op_wr    = use_in ? io_req_wr    : wr_q;
  assign op_addr  = use_in ? io_req_addr  : addr_q;
  assign op_wdata = use_in ? io_req_wdata : wdata_q;
  assign op_wstrb = use_in ? io_req_wstrb : wstrb_q;

  assign offset   = op_addr - BASE_ADDR;
  assign idx      = offset[SHIFT +: IDX_W];
  assign in_range = (op_addr >= BASE_ADDR) && ((offset >> (SHIFT + IDX_W)) == '0);
  assign we       = enter_resp && in_range && op_wr && !reset;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (io_resp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d   = !in_range;
      rdata_d = (in_range && !op_wr) ? mem_q[idx] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      live_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      wr_q    <= io_req_wr;
      addr_q  <= io_req_addr;
      wdata_q <= io_req_wdata;
      wstrb_q <= io_req_wstrb;
    end
  end

  // Array contents survive reset
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (op_wstrb[i]) mem_q[idx][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/mem_hs.md
# mem_hs

Parametrised data-memory block that supersedes the single-cycle combinational memory wrapper. It adds an internal word array with a valid/ready request channel and a valid/ready response channel. It also provides a configurable access latency, byte-strobe writes, and address-range checking with an error flag. It sits between the core's load/store unit and the data-memory address window, and models a multi-cycle memory so pipeline stall logic can be exercised.

## Interface
- DATA_W, 32, data width in bits; multiple of 8, power of two.
- ADDR_W, 32, byte-address width.
- DEPTH, 1024, number of DATA_W words in the array; power of two.
- LATENCY, 1, cycles from request acceptance to response valid; legal range 1..15.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- io_req_valid  input  1  request present.
- io_req_ready  output  1  block can accept a request.
- io_req_wr  input  1  1 = write, 0 = read.
- io_req_addr  input  ADDR_W  byte address.
- io_req_wdata  input  DATA_W  write data.
- io_req_wstrb  input  DATA_W/8  byte-lane write enables; bit i covers wdata[8i+7:8i].
- io_resp_valid  output  1  response present.
- io_resp_ready  input  1  consumer accepts the response.
- io_resp_rdata  output  DATA_W  read data; 0 for writes and errors.
- io_resp_err  output  1  address outside the array window.

## Operation
- State machine with states IDLE, WAIT and RESP.
  - IDLE: io_req_ready=1.
  - WAIT: latency countdown; io_req_ready=0.
  - RESP: io_resp_valid=1; io_req_ready=0.
- Request handshake is io_req_valid & io_req_ready in IDLE. wr, addr, wdata and wstrb are latched at that edge. Request inputs are don't-care at all other times.
- At acceptance, the block leaves IDLE:
  - If LATENCY=1, it goes to RESP.
  - Otherwise it goes to WAIT with a 4-bit counter loaded with LATENCY-2.
- WAIT: the counter decrements each cycle. When the counter is 0, the block goes to RESP.
- Array access happens on the edge that enters RESP.
  - Word index = (addr - BASE_ADDR) >> log2(DATA_W/8). Low offset bits are ignored; there is no misalignment fault.
  - Out of range means addr < BASE_ADDR or index >= DEPTH. In that case err=1, the array is unchanged and rdata=0.
  - Read: rdata = array[index] and err=0.
  - Write: each lane with wstrb[i]=1 is updated. rdata=0 and err=0. wstrb=0 is a legal no-op write.
- RESP: io_resp_valid, io_resp_rdata and io_resp_err are held stable until io_resp_ready=1. On the response handshake the block returns to IDLE.
- There is only one outstanding request, so there is no overlap.
- The array contents are not reset, and reset does not clear them.

## Timing
- Reset (synchronous, sampled on the edge):
  - State goes to IDLE and the counter to 0.
  - io_resp_valid=0, io_resp_rdata=0, io_resp_err=0.
  - io_req_ready=0 while reset is high, and 1 in the first cycle after reset deasserts.
- Latency: a request accepted on edge t gives io_resp_valid=1 from cycle t+LATENCY onward.
- Best-case throughput is one request per LATENCY+1 cycles, with io_resp_ready held at 1.
- A write commits at the RESP-entry edge. A read issued after that write's response returns the new data.
- Reset asserted in WAIT or RESP:
  - The in-flight request is dropped and no response is produced.
  - A write that has not yet reached the RESP-entry edge is not committed.
- io_resp_ready=1 outside RESP is ignored.
- All outputs are driven from registers or from state decode. There is no combinational path from any input to any output.

## Test plan
- Reset: hold reset for 3 cycles with random inputs. Required: io_req_ready=0, io_resp_valid=0, rdata=0 and err=0 during reset; io_req_ready=1 on the next cycle.
- Latency with LATENCY=3:
  - Write 0xDEADBEEF to 0x8000_0010 with wstrb=4'hF. Required: resp_valid exactly 3 cycles after acceptance, err=0, rdata=0.
  - Then read 0x8000_0010. Required: rdata=0xDEADBEEF.
- Strobes: word at 0x8000_0020 holds 0x11223344. Write 0xAABBCCDD with wstrb=4'b0101. Required: a read returns 0x11BB33DD.
- Backpressure: during a read response, hold io_resp_ready=0 for 5 cycles. Required: resp_valid, rdata and err stay constant, and io_req_ready stays 0 throughout. Return to IDLE happens on the cycle after io_resp_ready=1.
- Range errors, with DEPTH=1024 and DATA_W=32:
  - Read 0x8000_1000 (index 1024) and read 0x7FFF_FFFC. Required: err=1 and rdata=0 for both.
  - Write 0x8000_1000 with data 0x5A5A5A5A. Required: a subsequent read of word 0 (0x8000_0000) is unchanged.
- Reset mid-access with LATENCY=4:
  - Accept a write of 0x12345678 to 0x8000_0000, whose prior contents are 0. Assert reset 2 cycles later.
  - Required: no resp_valid appears, and a post-reset read returns 0x00000000.
